// File: rtl/lsu_module.sv
// lsu_module: load/store unit between the execute stage and a single-word data memory.
// One access is in flight at a time. Legal accesses issue a word-aligned memory request
// and wait for dmem_ack (bounded by TIMEOUT_CYCLES). Illegal or misaligned accesses
// answer immediately without touching memory.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid / req_ready access handshake from execute (ready only while idle)
//   is_store, funct3      access kind and width/sign code (B, H, W, BU, HU)
//   addr, store_data      effective address and right-aligned store value
//   rd_in                 load destination, echoed on resp_rd
//   dmem_req/we/addr/     memory request, held until acknowledged or timed out
//   wdata/wstrb
//   dmem_rdata, dmem_ack  memory read word and one-cycle completion
//   resp_valid            one-cycle completion pulse
//   resp_data/rd/err      response payload, held until the next response
module lsu_module #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsuState_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Last REQ cycle index before giving up; the counter starts at 0 on entry to REQ.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsuState_t   r_state;
  logic [7:0]  r_count;
  logic [1:0]  r_addrLo;
  logic [2:0]  r_funct3;
  logic        r_isStore;
  logic [4:0]  r_rd;

  logic        w_illegal;
  logic        w_misaligned;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  assign req_ready = (r_state == IDLE);

  // Signed stores (funct3[2]=1) have no meaning, so they join the reserved codes.
  assign w_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                     (is_store && funct3[2]);

  // funct3[1:0] gives the size for both signed and unsigned variants.
  assign w_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // Store data is replicated across all lanes; the strobes pick the lanes written.
  always_comb begin
    w_wdata = 32'd0;
    w_wstrb = 4'b0000;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          w_wdata = {4{store_data[7:0]}};
          w_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          w_wdata = {2{store_data[15:0]}};
          w_wstrb = 4'b0011 << addr[1:0];
        end
        default: begin
          w_wdata = store_data;
          w_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Lane selection and extension of the returned word, using the captured access info.
  always_comb begin
    case (r_addrLo)
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      2'd3:    w_byte = dmem_rdata[31:24];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_addrLo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'd0, w_byte};
      3'b101:  w_loadData = {16'd0, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_addrLo   <= 2'd0;
      r_funct3   <= 3'd0;
      r_isStore  <= 1'b0;
      r_rd       <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_wstrb <= 4'b0000;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_rd    <= 5'd0;
      resp_err   <= ERR_OK;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addrLo  <= addr[1:0];
            r_funct3  <= funct3;
            r_isStore <= is_store;
            r_rd      <= rd_in;
            r_count   <= 8'd0;
            if (w_illegal || w_misaligned) begin
              // Illegal wins over misaligned when both apply.
              r_state    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= w_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
              resp_data  <= 32'd0;
              resp_rd    <= rd_in;
            end else begin
              r_state    <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wdata <= w_wdata;
              dmem_wstrb <= w_wstrb;
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still completes normally.
          if (dmem_ack) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_data  <= r_isStore ? 32'd0 : w_loadData;
            resp_rd    <= r_rd;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
          end else if (r_count == TIMEOUT_LAST) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_TIMEOUT;
            resp_data  <= 32'd0;
            resp_rd    <= r_rd;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_wstrb <= 4'b0000;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_module.sv
// Testbench for lsu_module: a table of directed accesses with hand-derived expectations,
// randomized accesses checked against a behavioural model, and a reset-during-request
// sequence. The memory side is driven directly: each access states after how many
// request cycles the ack arrives (a delay at or beyond the timeout means no ack).
module tb_lsu_module;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ackDelay;
    logic [4:0]  rd;
    logic [1:0]  expErr;
    logic [31:0] expData;
    logic [31:0] expWdata;
    logic [3:0]  expWstrb;
  } vec_t;

  vec_t table_v[14];

  lsu_module #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mkVec(input logic isSt, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdat, input int dly,
                                 input logic [4:0] rd, input logic [1:0] eErr,
                                 input logic [31:0] eData, input logic [31:0] eWdata,
                                 input logic [3:0] eWstrb);
    vec_t v;
    v.isStore = isSt; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rdat;
    v.ackDelay = dly; v.rd = rd; v.expErr = eErr; v.expData = eData;
    v.expWdata = eWdata; v.expWstrb = eWstrb;
    return v;
  endfunction

  // Behavioural reference: access size/sign from the code, lane arithmetic on integers.
  function automatic vec_t refModel(input vec_t vin);
    vec_t   v;
    int     size;
    bit     sgn;
    bit     ok;
    int     lane;
    longint val;
    v    = vin;
    ok   = 1'b1;
    sgn  = 1'b0;
    size = 1;
    case (v.f3)
      3'd0:    begin size = 1; sgn = 1'b1; end
      3'd1:    begin size = 2; sgn = 1'b1; end
      3'd2:    size = 4;
      3'd4:    size = 1;
      3'd5:    size = 2;
      default: ok = 1'b0;
    endcase
    if (v.isStore && v.f3[2]) ok = 1'b0;
    lane       = int'(v.addr[1:0]);
    v.expData  = 32'd0;
    v.expWdata = 32'd0;
    v.expWstrb = 4'd0;
    if (!ok)                       v.expErr = 2'b11;
    else if ((lane % size) != 0)   v.expErr = 2'b01;
    else if (v.ackDelay >= TIMEOUT) v.expErr = 2'b10;
    else                           v.expErr = 2'b00;
    if (ok && v.isStore) begin
      v.expWstrb = 4'(((1 << size) - 1) << lane);
      for (int i = 0; i < 4; i++) v.expWdata[8*i +: 8] = v.sdata[8*(i % size) +: 8];
    end
    if (v.expErr == 2'b00 && !v.isStore) begin
      val = (longint'(v.rdata) >> (8 * lane)) & ((longint'(1) << (8 * size)) - 1);
      if (sgn && val >= (longint'(1) << (8 * size - 1))) val = val - (longint'(1) << (8 * size));
      v.expData = val[31:0];
    end
    return v;
  endfunction

  // Runs one access starting in an IDLE cycle (#1 after a rising edge) and ends in the
  // following IDLE cycle, so consecutive calls are back-to-back.
  task automatic applyStimulus(input vec_t v);
    bit done;
    int c;
    checkOutput("ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    is_store   = v.isStore;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sdata;
    rd_in      = v.rd;
    @(posedge clk); #1;
    // Keep presenting junk while busy; it must be ignored.
    addr       = $urandom();
    funct3     = 3'($urandom());
    store_data = $urandom();
    rd_in      = 5'($urandom());
    if (v.expErr == 2'b00 || v.expErr == 2'b10) begin
      done = 1'b0;
      c    = 0;
      while (!done && c < TIMEOUT) begin
        checkOutput("dmem_req", 32'(dmem_req), 32'd1);
        checkOutput("ready_busy", 32'(req_ready), 32'd0);
        checkOutput("resp_valid_req", 32'(resp_valid), 32'd0);
        checkOutput("dmem_addr", dmem_addr, {v.addr[31:2], 2'b00});
        checkOutput("dmem_we", 32'(dmem_we), 32'(v.isStore));
        checkOutput("dmem_wstrb", 32'(dmem_wstrb), 32'(v.expWstrb));
        if (v.isStore) checkOutput("dmem_wdata", dmem_wdata, v.expWdata);
        if (c == v.ackDelay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
          done       = 1'b1;
        end else begin
          dmem_rdata = $urandom();
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom();
        c++;
      end
    end
    checkOutput("resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("resp_err", 32'(resp_err), 32'(v.expErr));
    checkOutput("resp_data", resp_data, v.expData);
    checkOutput("resp_rd", 32'(resp_rd), 32'(v.rd));
    checkOutput("dmem_req_resp", 32'(dmem_req), 32'd0);
    checkOutput("ready_resp", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("resp_valid_drop", 32'(resp_valid), 32'd0);
    checkOutput("ready_back", 32'(req_ready), 32'd1);
    checkOutput("resp_err_hold", 32'(resp_err), 32'(v.expErr));
    checkOutput("resp_data_hold", resp_data, v.expData);
    checkOutput("resp_rd_hold", 32'(resp_rd), 32'(v.rd));
  endtask

  initial begin
    vec_t rv;
    // Directed vectors: {store, funct3, addr, store_data, rdata, ackDelay, rd, err, data, wdata, wstrb}
    table_v[0]  = mkVec(1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_0000, 3,  5'd5,  2'b00, 32'hFFFF_FF80, 32'h0,         4'h0);
    table_v[1]  = mkVec(1'b1, 3'b001, 32'h22,  32'h1234_ABCD, 32'h0,         0,  5'd6,  2'b00, 32'h0,         32'hABCD_ABCD, 4'hC);
    table_v[2]  = mkVec(1'b0, 3'b010, 32'h06,  32'h0,         32'h0,         0,  5'd7,  2'b01, 32'h0,         32'h0,         4'h0);
    table_v[3]  = mkVec(1'b0, 3'b011, 32'h00,  32'h0,         32'h0,         0,  5'd8,  2'b11, 32'h0,         32'h0,         4'h0);
    table_v[4]  = mkVec(1'b0, 3'b101, 32'h40,  32'h0,         32'hFFFF_FFFF, 99, 5'd9,  2'b10, 32'h0,         32'h0,         4'h0);
    table_v[5]  = mkVec(1'b1, 3'b010, 32'h10,  32'hDEAD_BEEF, 32'h0,         0,  5'd10, 2'b00, 32'h0,         32'hDEAD_BEEF, 4'hF);
    table_v[6]  = mkVec(1'b0, 3'b100, 32'h11,  32'h0,         32'h1234_5678, 0,  5'd11, 2'b00, 32'h56,        32'h0,         4'h0);
    table_v[7]  = mkVec(1'b1, 3'b100, 32'h04,  32'h77,        32'h0,         0,  5'd12, 2'b11, 32'h0,         32'h0,         4'h0);
    table_v[8]  = mkVec(1'b0, 3'b001, 32'h02,  32'h0,         32'h8001_0000, 1,  5'd13, 2'b00, 32'hFFFF_8001, 32'h0,         4'h0);
    table_v[9]  = mkVec(1'b1, 3'b000, 32'h03,  32'hA5,        32'h0,         0,  5'd14, 2'b00, 32'h0,         32'hA5A5_A5A5, 4'h8);
    table_v[10] = mkVec(1'b0, 3'b101, 32'h05,  32'h0,         32'h0,         0,  5'd15, 2'b01, 32'h0,         32'h0,         4'h0);
    table_v[11] = mkVec(1'b0, 3'b110, 32'h03,  32'h0,         32'h0,         0,  5'd16, 2'b11, 32'h0,         32'h0,         4'h0);
    table_v[12] = mkVec(1'b0, 3'b010, 32'h08,  32'h0,         32'hCAFE_F00D, 2,  5'd17, 2'b00, 32'hCAFE_F00D, 32'h0,         4'h0);
    table_v[13] = mkVec(1'b0, 3'b000, 32'h200, 32'h0,         32'h1234_567F, 0,  5'd18, 2'b00, 32'h7F,        32'h0,         4'h0);

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'd0;
    addr       = 32'd0;
    store_data = 32'd0;
    rd_in      = 5'd0;
    dmem_rdata = 32'd0;
    dmem_ack   = 1'b0;

    #12;
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_dmem_we", 32'(dmem_we), 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_dmem_wstrb", 32'(dmem_wstrb), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_rd", 32'(resp_rd), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst", 32'(req_ready), 32'd1);

    $display("[TB] directed table");
    for (int i = 0; i < 14; i++) applyStimulus(table_v[i]);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 60; i++) begin
      rv.isStore  = 1'($urandom_range(0, 1));
      rv.f3       = 3'($urandom_range(0, 7));
      rv.addr     = $urandom();
      if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
      rv.sdata    = $urandom();
      rv.rdata    = $urandom();
      rv.ackDelay = $urandom_range(0, TIMEOUT + 1);
      rv.rd       = 5'($urandom());
      rv          = refModel(rv);
      applyStimulus(rv);
    end

    $display("[TB] reset during request");
    req_valid = 1'b1;
    is_store  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h20;
    rd_in     = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("mid_req_active", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("mid_rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("mid_rst_resp_data", resp_data, 32'd0);
    checkOutput("mid_rst_resp_rd", 32'(resp_rd), 32'd0);
    checkOutput("mid_rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("late_ack_no_resp", 32'(resp_valid), 32'd0);
    checkOutput("late_ack_no_req", 32'(dmem_req), 32'd0);
    checkOutput("late_ack_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("no_replay_resp", 32'(resp_valid), 32'd0);
    checkOutput("no_replay_req", 32'(dmem_req), 32'd0);
    applyStimulus(table_v[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
